// File: rtl/inst_cache_assoc_if.sv
// Fetch-side and refill-bus signals of the set-associative instruction cache.
// master = CPU fetch unit plus read bus; slave = the cache itself.
interface inst_cache_assoc_if #(
    parameter int BLK_W = 128
);
    logic             inst_rreq;
    logic [31:0]      inst_addr;
    logic             inst_valid;
    logic [31:0]      inst_out;
    logic             inst_flush;
    logic             flush_done;
    logic             dev_rrdy;
    logic [3:0]       cpu_ren;
    logic [31:0]      cpu_raddr;
    logic             dev_rvalid;
    logic [BLK_W-1:0] dev_rdata;
    logic [31:0]      hit_cnt;
    logic [31:0]      miss_cnt;

    modport master (
        output inst_rreq, inst_addr, inst_flush,
        output dev_rrdy, dev_rvalid, dev_rdata,
        input  inst_valid, inst_out, flush_done,
        input  cpu_ren, cpu_raddr, hit_cnt, miss_cnt
    );

    modport slave (
        input  inst_rreq, inst_addr, inst_flush,
        input  dev_rrdy, dev_rvalid, dev_rdata,
        output inst_valid, inst_out, flush_done,
        output cpu_ren, cpu_raddr, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/inst_cache_assoc.sv
// N-way set-associative read-only instruction cache with true-LRU,
// critical-word return on refill, whole-cache flush and hit/miss counters.
module inst_cache_assoc #(
    parameter int WAYS      = 2,
    parameter int SETS      = 64,
    parameter int BLK_WORDS = 4
) (
    input logic               cpu_clk,
    input logic               cpu_rst,
    inst_cache_assoc_if.slave bus
);
    localparam int OFF_W = $clog2(BLK_WORDS) + 2;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - OFF_W;
    localparam int BLK_W = 32 * BLK_WORDS;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int AGE_W = WAY_W;
    localparam int SEL_W = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_MISS, S_REFILL, S_FLUSH
    } state_t;

    state_t state_q, state_d;

    logic             valid_q [SETS][WAYS];
    logic             valid_d [SETS][WAYS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [TAG_W-1:0] tag_d   [SETS][WAYS];
    logic [AGE_W-1:0] age_q   [SETS][WAYS];
    logic [AGE_W-1:0] age_d   [SETS][WAYS];
    logic [BLK_W-1:0] data_q  [SETS][WAYS];

    logic [31:2] addr_q, addr_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_out_q, inst_out_d;
    logic        flush_done_q, flush_done_d;
    logic [3:0]  cpu_ren_q, cpu_ren_d;
    logic [31:0] cpu_raddr_q, cpu_raddr_d;
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [SEL_W-1:0] req_word;

    logic             hit_any;
    logic [WAY_W-1:0] hit_way;
    logic             inv_any;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] victim_way;
    logic [BLK_W-1:0] hit_line;
    logic [31:0]      hit_word;
    logic [31:0]      fill_word;

    logic             fill_en;
    logic             touch_en;
    logic [WAY_W-1:0] touch_way;
    logic [AGE_W-1:0] touch_age;

    assign req_tag = addr_q[31 -: TAG_W];
    assign req_idx = addr_q[OFF_W +: IDX_W];

    if (BLK_WORDS > 1) begin : g_word
        assign req_word = addr_q[OFF_W-1:2];
    end else begin : g_word1
        assign req_word = '0;
    end

    assign hit_line   = data_q[req_idx][hit_way];
    assign hit_word   = hit_line[{req_word, 5'b0} +: 32];
    assign fill_word  = bus.dev_rdata[{req_word, 5'b0} +: 32];
    assign victim_way = inv_any ? inv_way : lru_way;

    // Tag compare and victim choice for the latched set; lowest index wins.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        lru_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_idx][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
            if (age_q[req_idx][w] == AGE_W'(WAYS - 1)) begin
                lru_way = WAY_W'(w);
            end
        end
    end

    // Controller: next state, registered outputs, tag/valid/age updates.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        inst_valid_d = 1'b0;
        inst_out_d   = inst_out_q;
        flush_done_d = 1'b0;
        cpu_ren_d    = 4'h0;
        cpu_raddr_d  = cpu_raddr_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        age_d        = age_q;
        fill_en      = 1'b0;
        touch_en     = 1'b0;
        touch_way    = '0;
        touch_age    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.inst_flush) begin
                    state_d = S_FLUSH;
                end else if (bus.inst_rreq) begin
                    addr_d  = bus.inst_addr[31:2];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit_any) begin
                    inst_valid_d = 1'b1;
                    inst_out_d   = hit_word;
                    touch_en     = 1'b1;
                    touch_way    = hit_way;
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
                    state_d = S_IDLE;
                end else begin
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
                    state_d = S_MISS;
                end
            end
            S_MISS: begin
                if (bus.dev_rrdy) begin
                    cpu_ren_d   = 4'hF;
                    cpu_raddr_d = {req_tag, req_idx, {OFF_W{1'b0}}};
                    state_d     = S_REFILL;
                end
            end
            S_REFILL: begin
                if (bus.dev_rvalid) begin
                    fill_en = 1'b1;
                    valid_d[req_idx][victim_way] = 1'b1;
                    tag_d[req_idx][victim_way]   = req_tag;
                    touch_en     = 1'b1;
                    touch_way    = victim_way;
                    inst_valid_d = 1'b1;
                    inst_out_d   = fill_word;
                    state_d      = S_IDLE;
                end
            end
            S_FLUSH: begin
                for (int s = 0; s < SETS; s++) begin
                    for (int w = 0; w < WAYS; w++) begin
                        valid_d[s][w] = 1'b0;
                        age_d[s][w]   = AGE_W'(w);
                    end
                end
                flush_done_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (touch_en) begin
            touch_age = age_q[req_idx][touch_way];
            for (int v = 0; v < WAYS; v++) begin
                if (age_q[req_idx][v] < touch_age) begin
                    age_d[req_idx][v] = age_q[req_idx][v] + AGE_W'(1);
                end
            end
            age_d[req_idx][touch_way] = '0;
        end
    end

    // Control and metadata registers; reset clears valids and restores ages.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            inst_valid_q <= 1'b0;
            inst_out_q   <= '0;
            flush_done_q <= 1'b0;
            cpu_ren_q    <= 4'h0;
            cpu_raddr_q  <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    age_q[s][w]   <= AGE_W'(w);
                end
            end
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            inst_valid_q <= inst_valid_d;
            inst_out_q   <= inst_out_d;
            flush_done_q <= flush_done_d;
            cpu_ren_q    <= cpu_ren_d;
            cpu_raddr_q  <= cpu_raddr_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            age_q        <= age_d;
        end
    end

    // Line data needs no reset: it is only read behind a valid bit.
    always_ff @(posedge cpu_clk) begin
        if (fill_en) begin
            data_q[req_idx][victim_way] <= bus.dev_rdata;
        end
    end

    assign bus.inst_valid = inst_valid_q;
    assign bus.inst_out   = inst_out_q;
    assign bus.flush_done = flush_done_q;
    assign bus.cpu_ren    = cpu_ren_q;
    assign bus.cpu_raddr  = cpu_raddr_q;
    assign bus.hit_cnt    = hit_cnt_q;
    assign bus.miss_cnt   = miss_cnt_q;
endmodule

// File: tb/tb_inst_cache_assoc.sv
// Directed bench for inst_cache_assoc (2 ways, 64 sets, 4-word lines).
// Each refill word is its own address xor 32'hA5A5_0000.
module tb_inst_cache_assoc;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    inst_cache_assoc_if #(.BLK_W(128)) bus ();

    inst_cache_assoc #(
        .WAYS(2), .SETS(64), .BLK_WORDS(4)
    ) dut (
        .cpu_clk (clk),
        .cpu_rst (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wexp(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [127:0] mk_line(input logic [31:0] base);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = wexp(base + 32'(4 * k));
        return l;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one fetch, answer any refill, check latency/word/bus traffic.
    task automatic fetch(input string tag, input logic [31:0] a,
                         input bit miss, input int rrdy_rise);
        int          lat;
        int          ren_n;
        int          ren_first;
        int          exp_lat;
        int          exp_rf;
        logic [31:0] ra;
        logic [31:0] wd;
        bit          got;
        lat = 0; ren_n = 0; ren_first = 0; ra = '0; wd = '0; got = 0;
        exp_rf  = (rrdy_rise > 2) ? rrdy_rise + 1 : 3;
        exp_lat = miss ? exp_rf + 1 : 2;
        @(negedge clk);
        bus.inst_addr = a;
        bus.inst_rreq = 1'b1;
        bus.dev_rrdy  = (rrdy_rise == 0);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus.cpu_ren !== 4'h0) begin
                if (ren_n == 0) ren_first = c;
                ren_n++;
                ra = bus.cpu_raddr;
                chk({tag, "_ren_val"}, 32'(bus.cpu_ren), 32'hF);
            end
            if (bus.inst_valid === 1'b1) begin
                got = 1;
                lat = c;
                wd  = bus.inst_out;
            end
            @(negedge clk);
            bus.inst_rreq  = 1'b0;
            bus.dev_rvalid = (bus.cpu_ren !== 4'h0);
            bus.dev_rdata  = mk_line(a & ~32'hF);
            if (c >= rrdy_rise) bus.dev_rrdy = 1'b1;
            if (got) break;
        end
        chk({tag, "_got"}, 32'(got), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_word"}, wd, wexp(a));
        chk({tag, "_ren_n"}, 32'(ren_n), miss ? 32'd1 : 32'd0);
        if (miss) begin
            chk({tag, "_raddr"}, ra, a & ~32'hF);
            chk({tag, "_ren_at"}, 32'(ren_first), 32'(exp_rf));
        end
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(bus.inst_valid), 32'd0);
    endtask

    initial begin
        bit seen;
        bus.inst_rreq  = 1'b0;
        bus.inst_addr  = '0;
        bus.inst_flush = 1'b0;
        bus.dev_rrdy   = 1'b1;
        bus.dev_rvalid = 1'b0;
        bus.dev_rdata  = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_out", bus.inst_out, 32'd0);
        chk("rst_fdone", 32'(bus.flush_done), 32'd0);
        chk("rst_ren", 32'(bus.cpu_ren), 32'd0);
        chk("rst_raddr", bus.cpu_raddr, 32'd0);
        chk("rst_hit", bus.hit_cnt, 32'd0);
        chk("rst_miss", bus.miss_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        fetch("t1_0100", 32'h0000_0100, 1, 0);
        chk("t1_miss", bus.miss_cnt, 32'd1);
        chk("t1_hit", bus.hit_cnt, 32'd0);

        fetch("t2_0104", 32'h0000_0104, 0, 0);
        chk("t2_hit", bus.hit_cnt, 32'd1);

        fetch("t3_0000", 32'h0000_0000, 1, 0);
        fetch("t3_0400", 32'h0000_0400, 1, 0);
        fetch("t3_0008", 32'h0000_0008, 0, 0);
        fetch("t3_0800", 32'h0000_0800, 1, 0);
        fetch("t3_000c", 32'h0000_000C, 0, 0);
        fetch("t3_0404", 32'h0000_0404, 1, 0);
        chk("t3_hit", bus.hit_cnt, 32'd3);
        chk("t3_miss", bus.miss_cnt, 32'd5);

        fetch("t4_0200", 32'h0000_0200, 1, 7);
        chk("t4_miss", bus.miss_cnt, 32'd6);

        fetch("t5_pre", 32'h0000_0108, 0, 0);
        @(negedge clk);
        bus.inst_flush = 1'b1;
        @(posedge clk); #1;
        chk("t5_fd0", 32'(bus.flush_done), 32'd0);
        @(negedge clk);
        bus.inst_flush = 1'b0;
        @(posedge clk); #1;
        chk("t5_fd1", 32'(bus.flush_done), 32'd1);
        @(posedge clk); #1;
        chk("t5_fd2", 32'(bus.flush_done), 32'd0);
        fetch("t5_0100", 32'h0000_0100, 1, 0);
        fetch("t5_0000", 32'h0000_0000, 1, 0);
        fetch("t5_0200", 32'h0000_0200, 1, 0);
        chk("t5_hit", bus.hit_cnt, 32'd4);
        chk("t5_miss", bus.miss_cnt, 32'd9);

        @(negedge clk);
        bus.inst_addr = 32'h0000_0300;
        bus.inst_rreq = 1'b1;
        seen = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (bus.cpu_ren !== 4'h0) seen = 1;
            @(negedge clk);
            bus.inst_rreq = 1'b0;
            if (seen) break;
        end
        chk("t6_in_refill", 32'(seen), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_hit", bus.hit_cnt, 32'd0);
        chk("t6_rst_miss", bus.miss_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.dev_rvalid = 1'b1;
        bus.dev_rdata  = mk_line(32'h0000_0300);
        @(posedge clk); #1;
        chk("t6_no_valid0", 32'(bus.inst_valid), 32'd0);
        @(negedge clk);
        bus.dev_rvalid = 1'b0;
        @(posedge clk); #1;
        chk("t6_no_valid1", 32'(bus.inst_valid), 32'd0);
        chk("t6_ren", 32'(bus.cpu_ren), 32'd0);
        fetch("t6_0300", 32'h0000_0300, 1, 0);
        chk("t6_miss", bus.miss_cnt, 32'd1);
        chk("t6_hit", bus.hit_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
